// File: rtl/line_fill_buffer.sv
// Line fill buffer: fetches one 128-bit line from physical memory as BEAT_W-bit
// beats and hands the assembled line to the cache data array with a done pulse.
module line_fill_buffer #(
  parameter int BEAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_req,
  input  logic [15:0]       fill_addr,
  output logic              pmem_read,
  output logic [15:0]       pmem_address,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy,
  output logic              fill_done,
  output logic [127:0]      fill_line
);

  localparam int BEATS = 128 / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;

  // The byte offset within the line never reaches memory; the request is line-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^fill_addr[3:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      pmem_read    <= 1'b0;
      pmem_address <= 16'h0000;
      busy         <= 1'b0;
      fill_done    <= 1'b0;
      fill_line    <= '0;
    end else begin
      case (state)
        IDLE: begin
          fill_done <= 1'b0;
          if (fill_req) begin
            pmem_address <= {fill_addr[15:4], 4'b0000};
            beat_cnt     <= '0;
            pmem_read    <= 1'b1;
            busy         <= 1'b1;
            state        <= FETCH;
          end
        end

        FETCH: begin
          if (pmem_resp) begin
            fill_line[beat_cnt*BEAT_W +: BEAT_W] <= pmem_rdata;
            beat_cnt <= beat_cnt + 1'b1;
            // Leaving on the last capture edge drops the read request immediately.
            if (beat_cnt == LAST_BEAT) begin
              pmem_read <= 1'b0;
              busy      <= 1'b0;
              fill_done <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          fill_done <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          pmem_read <= 1'b0;
          busy      <= 1'b0;
          fill_done <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_buffer.sv
// Bench for line_fill_buffer: a 32-bit-beat instance checked every cycle against
// a transaction-level model, plus directed runs of 16-bit and 128-bit builds.
module tb_line_fill_buffer;

  localparam logic [127:0] LINE_A = 128'h77776666_55554444_33332222_11110000;
  localparam logic [127:0] LINE_B = 128'hBBBB3333_BBBB2222_BBBB1111_BBBB0000;
  localparam logic [127:0] LINE_C = 128'hC0C0C0C3_C0C0C0C2_C0C0C0C1_C0C0C0C0;
  localparam logic [127:0] LINE_D = 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_CAFEF00D;
  localparam logic [127:0] LINE_W = 128'h77776666_55554444_33332222_11110000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fill_req;
  logic [15:0]  fill_addr;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic [31:0]  pmem_rdata;
  logic         pmem_resp;
  logic         busy;
  logic         fill_done;
  logic [127:0] fill_line;

  logic         fill_req_16, pmem_resp_16, pmem_read_16, busy_16, fill_done_16;
  logic [15:0]  fill_addr_16, pmem_address_16, pmem_rdata_16;
  logic [127:0] fill_line_16;

  logic         fill_req_128, pmem_resp_128, pmem_read_128, busy_128, fill_done_128;
  logic [15:0]  fill_addr_128, pmem_address_128;
  logic [127:0] pmem_rdata_128, fill_line_128;

  int passed = 0;
  int total  = 0;
  int cyc = 0;
  int req_edge = 0;
  int done_count = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  line_fill_buffer #(.BEAT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .fill_req(fill_req), .fill_addr(fill_addr),
    .pmem_read(pmem_read), .pmem_address(pmem_address), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .busy(busy), .fill_done(fill_done), .fill_line(fill_line)
  );

  line_fill_buffer #(.BEAT_W(16)) dut_16 (
    .clk(clk), .rst_n(rst_n), .fill_req(fill_req_16), .fill_addr(fill_addr_16),
    .pmem_read(pmem_read_16), .pmem_address(pmem_address_16), .pmem_rdata(pmem_rdata_16),
    .pmem_resp(pmem_resp_16), .busy(busy_16), .fill_done(fill_done_16), .fill_line(fill_line_16)
  );

  line_fill_buffer #(.BEAT_W(128)) dut_128 (
    .clk(clk), .rst_n(rst_n), .fill_req(fill_req_128), .fill_addr(fill_addr_128),
    .pmem_read(pmem_read_128), .pmem_address(pmem_address_128), .pmem_rdata(pmem_rdata_128),
    .pmem_resp(pmem_resp_128), .busy(busy_128), .fill_done(fill_done_128), .fill_line(fill_line_128)
  );

  // Model: a fill is "active" until four beats have arrived, then one done cycle.
  bit           m_active = 1'b0;
  bit           m_done = 1'b0;
  int           m_got = 0;
  logic [15:0]  m_addr = 16'h0000;
  logic [127:0] m_line = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (fill_done === 1'b1) done_count = done_count + 1;
    if (rst_n === 1'b0) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_got    = 0;
      m_addr   = 16'h0000;
      m_line   = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (fill_req === 1'b1) begin
        m_active = 1'b1;
        m_got    = 0;
        m_addr   = fill_addr & 16'hFFF0;
      end
    end else if (pmem_resp === 1'b1) begin
      m_line[m_got*32 +: 32] = pmem_rdata;
      m_got = m_got + 1;
      if (m_got == 4) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total = total + 1;
    if (act !== exp) $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    else passed = passed + 1;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_output("cyc_pmem_read", 128'(pmem_read), 128'(m_active));
      check_output("cyc_busy", 128'(busy), 128'(m_active));
      check_output("cyc_fill_done", 128'(fill_done), 128'(m_done));
      check_output("cyc_pmem_address", 128'(pmem_address), 128'(m_addr));
      check_output("cyc_fill_line", fill_line, m_line);
    end
  end

  task automatic start_fill(input logic [15:0] addr);
    fill_req  = 1'b1;
    fill_addr = addr;
    req_edge  = cyc + 1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [127:0] line, input int stall_after, input int stall_len);
    for (int i = 0; i < 4; i++) begin
      pmem_resp  = 1'b1;
      pmem_rdata = line[i*32 +: 32];
      @(negedge clk);
      if (i == stall_after) begin
        pmem_resp = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check_output("stall_busy", 128'(busy), 128'd1);
          @(negedge clk);
        end
      end
    end
    pmem_resp = 1'b0;
  endtask

  task automatic wait_done(output int latency);
    int n = 0;
    while (fill_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    latency = cyc - req_edge;
  endtask

  initial begin
    int lat;
    int d0;
    int n;
    rst_n = 1'b0; fill_req = 1'b0; fill_addr = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    fill_req_16 = 1'b0; fill_addr_16 = '0; pmem_rdata_16 = '0; pmem_resp_16 = 1'b0;
    fill_req_128 = 1'b0; fill_addr_128 = '0; pmem_rdata_128 = '0; pmem_resp_128 = 1'b0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    check_output("reset_pmem_read", 128'(pmem_read), 128'd0);
    check_output("reset_busy", 128'(busy), 128'd0);
    check_output("reset_fill_done", 128'(fill_done), 128'd0);
    check_output("reset_pmem_address", 128'(pmem_address), 128'd0);
    check_output("reset_fill_line", fill_line, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single fill");
    d0 = done_count;
    start_fill(16'h1236);
    check_output("fill1_address", 128'(pmem_address), 128'h1230);
    check_output("fill1_busy", 128'(busy), 128'd1);
    apply_stimulus(LINE_A, -1, 0);
    wait_done(lat);
    check_output("fill1_latency", 128'(lat), 128'd4);
    check_output("fill1_line", fill_line, LINE_A);
    check_output("fill1_read_dropped", 128'(pmem_read), 128'd0);
    check_output("model_line_pin", m_line, LINE_A);
    @(negedge clk);
    check_output("fill1_done_single", 128'(fill_done), 128'd0);
    @(negedge clk);
    check_output("fill1_done_count", 128'(done_count - d0), 128'd1);

    $display("[TB] responses while idle");
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    pmem_resp = 1'b0;
    @(negedge clk);
    check_output("idle_resp_line", fill_line, LINE_A);
    check_output("idle_resp_address", 128'(pmem_address), 128'h1230);
    check_output("idle_resp_busy", 128'(busy), 128'd0);

    $display("[TB] reset mid-fill");
    d0 = done_count;
    start_fill(16'h0A5C);
    pmem_resp = 1'b1;
    pmem_rdata = 32'h99990000;
    @(negedge clk);
    pmem_rdata = 32'h99991111;
    @(negedge clk);
    rst_n = 1'b0;
    pmem_rdata = 32'h99992222;
    @(negedge clk);
    pmem_resp = 1'b0;
    check_output("abort_pmem_read", 128'(pmem_read), 128'd0);
    check_output("abort_busy", 128'(busy), 128'd0);
    check_output("abort_fill_done", 128'(fill_done), 128'd0);
    check_output("abort_address", 128'(pmem_address), 128'd0);
    check_output("abort_line", fill_line, 128'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("abort_no_done", 128'(done_count - d0), 128'd0);
    start_fill(16'h0A5C);
    apply_stimulus(LINE_B, -1, 0);
    wait_done(lat);
    check_output("refill_latency", 128'(lat), 128'd4);
    check_output("refill_line", fill_line, LINE_B);
    check_output("refill_address", 128'(pmem_address), 128'h0A50);
    repeat (2) @(negedge clk);

    $display("[TB] stalled fill with address toggle");
    d0 = done_count;
    start_fill(16'h1236);
    fill_addr = 16'hABCD;
    apply_stimulus(LINE_A, 1, 3);
    wait_done(lat);
    check_output("stall_latency", 128'(lat), 128'd7);
    check_output("stall_line", fill_line, LINE_A);
    check_output("stall_address_held", 128'(pmem_address), 128'h1230);
    @(negedge clk);
    check_output("stall_done_single", 128'(fill_done), 128'd0);
    @(negedge clk);
    check_output("stall_done_count", 128'(done_count - d0), 128'd1);

    $display("[TB] back-to-back fills");
    fill_req  = 1'b1;
    fill_addr = 16'h2000;
    req_edge  = cyc + 1;
    @(negedge clk);
    fill_addr = 16'hFFFE;
    check_output("b2b_first_address", 128'(pmem_address), 128'h2000);
    apply_stimulus(LINE_C, -1, 0);
    wait_done(lat);
    check_output("b2b_first_latency", 128'(lat), 128'd4);
    check_output("b2b_first_line", fill_line, LINE_C);
    n = 0;
    while (busy !== 1'b1 && n < 8) begin
      check_output("b2b_line_stable", fill_line, LINE_C);
      @(negedge clk);
      n++;
    end
    fill_req = 1'b0;
    check_output("b2b_restart_gap", 128'(n), 128'd2);
    check_output("b2b_second_address", 128'(pmem_address), 128'hFFF0);
    check_output("b2b_line_before_beat", fill_line, LINE_C);
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check_output("b2b_first_beat", fill_line, 128'hC0C0C0C3_C0C0C0C2_C0C0C0C1_CAFEF00D);
    for (int i = 1; i < 4; i++) begin
      pmem_rdata = LINE_D[i*32 +: 32];
      @(negedge clk);
    end
    pmem_resp = 1'b0;
    check_output("b2b_second_done", 128'(fill_done), 128'd1);
    check_output("b2b_second_line", fill_line, LINE_D);
    repeat (2) @(negedge clk);

    $display("[TB] 16-bit beats");
    fill_req_16  = 1'b1;
    fill_addr_16 = 16'h0037;
    @(negedge clk);
    fill_req_16 = 1'b0;
    check_output("w16_address", 128'(pmem_address_16), 128'h0030);
    for (int k = 0; k < 8; k++) begin
      pmem_resp_16  = 1'b1;
      pmem_rdata_16 = 16'hA000 + 16'(k);
      @(negedge clk);
      if (k < 7) check_output("w16_not_done", 128'(fill_done_16), 128'd0);
      else       check_output("w16_done", 128'(fill_done_16), 128'd1);
    end
    pmem_resp_16 = 1'b0;
    check_output("w16_line", fill_line_16, 128'hA007A006_A005A004_A003A002_A001A000);
    check_output("w16_word5", 128'(fill_line_16[95:80]), 128'hA005);
    check_output("w16_read_dropped", 128'(pmem_read_16), 128'd0);

    $display("[TB] 128-bit beat");
    fill_req_128  = 1'b1;
    fill_addr_128 = 16'hBEEF;
    @(negedge clk);
    fill_req_128 = 1'b0;
    check_output("w128_busy", 128'(busy_128), 128'd1);
    pmem_resp_128  = 1'b1;
    pmem_rdata_128 = LINE_W;
    @(negedge clk);
    pmem_resp_128 = 1'b0;
    check_output("w128_done", 128'(fill_done_128), 128'd1);
    check_output("w128_line", fill_line_128, 128'h77776666_55554444_33332222_11110000);
    check_output("w128_word3", 128'(fill_line_128[63:48]), 128'h3333);
    check_output("w128_address", 128'(pmem_address_128), 128'hBEE0);
    @(negedge clk);
    check_output("w128_done_single", 128'(fill_done_128), 128'd0);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, total);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
